// File: rtl/pkt_delay_ring_if.sv
// Header-record handshake bundle for pkt_delay_ring: ingress (in_*) and egress (out_*) plus occupancy.
// slave is the ring's own view; master is the parser/scheduler side.
interface pkt_delay_ring_if #(
   parameter int DATA_W = 257,
   parameter int DEPTH  = 16,
   parameter int TM_W   = 6
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [TM_W-1:0]   in_delay;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  count;

   modport master (
      output in_valid, in_data, in_delay, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_data, in_delay, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/pkt_delay_ring.sv
// FIFO delay ring for header records: each slot holds a record and a residency timer; release is in order.
// Optional PKT_RING_FLUSH_EN adds a flush port that zeroes every held timer.
module pkt_delay_ring #(
   parameter int DATA_W = 257,
   parameter int DEPTH  = 16,
   parameter int TM_W   = 6
) (
   input logic clk,
   input logic rst,
`ifdef PKT_RING_FLUSH_EN
   input logic flush,
`endif
   pkt_delay_ring_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int PTR_W = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
      $error("pkt_delay_ring: DEPTH must be a power of two >= 2");
   end

   typedef logic [PTR_W-1:0] ptr_t;

   logic [DEPTH-1:0]  used;
   logic [TM_W-1:0]   tm  [DEPTH];
   logic [DATA_W-1:0] mem [DEPTH];
   ptr_t              wrPtr;
   ptr_t              rdPtr;
   logic [CNT_W-1:0]  cnt;
   logic              push;
   logic              pop;
   logic              flushNow;

`ifdef PKT_RING_FLUSH_EN
   assign flushNow = flush;
`else
   assign flushNow = 1'b0;
`endif

   // in_ready looks only at the registered count, never at a same-cycle pop
   assign bus.in_ready  = !rst && (cnt != CNT_W'(DEPTH));
   assign bus.out_valid = used[rdPtr] && (tm[rdPtr] == '0);
   assign bus.out_data  = mem[rdPtr];
   assign bus.count     = cnt;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         used  <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            tm[PTR_W'(i)] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (flushNow) begin
               tm[PTR_W'(i)] <= '0;
            end else if (used[PTR_W'(i)] && tm[PTR_W'(i)] != '0) begin
               tm[PTR_W'(i)] <= tm[PTR_W'(i)] - TM_W'(1);
            end
         end
         if (pop) begin
            used[rdPtr] <= 1'b0;
            rdPtr       <= rdPtr + ptr_t'(1);
         end
         // push never targets the popped slot: that would need the ring both empty and full
         if (push) begin
            used[wrPtr] <= 1'b1;
            tm[wrPtr]   <= flushNow ? '0 : bus.in_delay;
            wrPtr       <= wrPtr + ptr_t'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Record storage needs no reset; contents of free slots are never observed as valid
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr] <= bus.in_data;
      end
   end
endmodule

// File: tb/tb_pkt_delay_ring.sv
// Directed bench for pkt_delay_ring with a data scoreboard; exercises flush when PKT_RING_FLUSH_EN is defined.
module tb_pkt_delay_ring;
   localparam int DW = 257;
   localparam int DP = 16;
   localparam int TW = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
`ifdef PKT_RING_FLUSH_EN
   logic flush = 1'b0;
`endif
   int total = 0;
   int bad   = 0;
   logic [DW-1:0] sb[$];

   pkt_delay_ring_if #(.DATA_W(DW), .DEPTH(DP), .TM_W(TW)) bus ();

   pkt_delay_ring #(.DATA_W(DW), .DEPTH(DP), .TM_W(TW)) dut (
      .clk(clk),
      .rst(rst),
`ifdef PKT_RING_FLUSH_EN
      .flush(flush),
`endif
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk();
      return DW'({$urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom, $urandom, $urandom});
   endfunction

   // One clock: score any egress transfer and record any ingress transfer at the coming edge
   task automatic tick();
      logic          willPush;
      logic [DW-1:0] pushed;
      logic [DW-1:0] exp;
      @(negedge clk);
      willPush = bus.in_valid && bus.in_ready;
      pushed   = bus.in_data;
      if (bus.out_valid && bus.out_ready && !rst) begin
         if (sb.size() == 0) begin
            chk("spurious_out", DW'(bus.out_valid), '0);
         end else begin
            exp = sb.pop_front();
            chk("sb_order", bus.out_data, exp);
         end
      end
      @(posedge clk);
      if (willPush && !rst) sb.push_back(pushed);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic [TW-1:0] dly);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_delay = dly;
      while (!bus.in_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) chk("push_timeout", DW'(bus.in_ready), DW'(1));
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      chk("drain_left", DW'(sb.size()), '0);
   endtask

   initial begin
      logic [DW-1:0] a, b, held;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_delay  = '0;
      bus.out_ready = 1'b0;

      // Reset
      rst = 1'b1;
      tick();
      tick();
      chk("rst_in_ready", DW'(bus.in_ready), '0);
      chk("rst_count", DW'(bus.count), '0);
      chk("rst_out_valid", DW'(bus.out_valid), '0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", DW'(bus.in_ready), DW'(1));

      // Delay 0: valid the cycle after acceptance
      bus.out_ready = 1'b1;
      a = mk();
      push(a, 0);
      chk("d0_valid", DW'(bus.out_valid), DW'(1));
      chk("d0_data", bus.out_data, a);
      chk("d0_count1", DW'(bus.count), DW'(1));
      // Same-edge pop of the old head and push of a new one
      b = mk();
      bus.in_valid = 1'b1; bus.in_data = b; bus.in_delay = 0;
      tick();
      bus.in_valid = 1'b0;
      chk("swap_count", DW'(bus.count), DW'(1));
      chk("swap_data", bus.out_data, b);
      tick();
      chk("d0_count0", DW'(bus.count), '0);
      chk("d0_empty_valid", DW'(bus.out_valid), '0);

      // Head-of-line: A delay 5, B delay 0
      a = mk(); b = mk();
      push(a, 5);
      push(b, 0);
      chk("hol_count", DW'(bus.count), DW'(2));
      for (int k = 2; k <= 4; k++) begin
         tick();
         chk("hol_blocked", DW'(bus.out_valid), '0);
      end
      tick();
      chk("hol_a_valid", DW'(bus.out_valid), DW'(1));
      chk("hol_a_data", bus.out_data, a);
      tick();
      chk("hol_b_valid", DW'(bus.out_valid), DW'(1));
      chk("hol_b_data", bus.out_data, b);
      tick();
      chk("hol_empty", DW'(bus.count), '0);

      // Max delay boundary
      a = mk();
      push(a, 6'd63);
      for (int k = 0; k < 62; k++) tick();
      chk("dmax_early", DW'(bus.out_valid), '0);
      tick();
      chk("dmax_valid", DW'(bus.out_valid), DW'(1));
      chk("dmax_data", bus.out_data, a);
      tick();

      // Fill, stall, single pop, wrap-around stream
      bus.out_ready = 1'b0;
      for (int k = 0; k < DP; k++) push(mk(), 0);
      chk("full_count", DW'(bus.count), DW'(DP));
      chk("full_in_ready", DW'(bus.in_ready), '0);
      held = sb[0];
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("stall_valid", DW'(bus.out_valid), DW'(1));
         chk("stall_data", bus.out_data, held);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("pop1_count", DW'(bus.count), DW'(DP - 1));
      chk("pop1_in_ready", DW'(bus.in_ready), DW'(1));
      chk("pop1_next", bus.out_data, sb[0]);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 20; k++) push(mk(), TW'(k % 4));
      drain();
      tick();
      chk("wrap_count", DW'(bus.count), '0);

      // Reset with 7 headers held
      bus.out_ready = 1'b0;
      for (int k = 0; k < 7; k++) push(mk(), 3);
      chk("pre_rst_count", DW'(bus.count), DW'(7));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      #1;
      chk("mid_rst_count", DW'(bus.count), '0);
      chk("mid_rst_valid", DW'(bus.out_valid), '0);
      bus.out_ready = 1'b1;
      a = mk();
      push(a, 0);
      chk("after_rst_valid", DW'(bus.out_valid), DW'(1));
      chk("after_rst_data", bus.out_data, a);
      tick();
      chk("after_rst_alone", DW'(bus.out_valid), '0);
      for (int k = 0; k < 5; k++) tick();
      chk("after_rst_quiet", DW'(bus.out_valid), '0);

`ifdef PKT_RING_FLUSH_EN
      // Flush: four long-delay headers drain back to back
      for (int k = 0; k < 4; k++) push(mk(), 60);
      chk("fl_held", DW'(bus.out_valid), '0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("fl_valid", DW'(bus.out_valid), DW'(1));
         chk("fl_count", DW'(bus.count), DW'(4 - k));
         tick();
      end
      chk("fl_empty", DW'(bus.count), '0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pkt_delay_ring.md
# pkt_delay_ring

Parametrised delay ring for packet header records. Each accepted header occupies one ring slot with its own residency timer. Headers leave in arrival order, and none leaves before its requested delay has elapsed. The block sits between the header parser and the scheduler/egress stage, and replaces the fixed 6-bit-timer ring slot with configurable record width, depth and timer width, per-packet delay, backpressure on both sides, and an occupancy count.

## Interface
Parameters:
- DATA_W, 257, header record width (default is the full packed header: MACs, IPs, ports, seq, size, valid)
- DEPTH, 16, number of ring slots; power of two, at least 2
- TM_W, 6, timer/delay width in bits
- CNT_W, $clog2(DEPTH)+1, occupancy width (derived, not overridden)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  header offered
- in_ready  out  1  slot free; transfer when in_valid && in_ready
- in_data  in  DATA_W  header record
- in_delay  in  TM_W  minimum residency in cycles, sampled with in_data
- out_valid  out  1  head slot occupied and its timer expired
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- out_data  out  DATA_W  head slot record
- count  out  CNT_W  occupied slots, 0..DEPTH
- flush  in  1  force release of all held slots (only with PKT_RING_FLUSH_EN)

## Operation
- Per-slot state: used, tm[TM_W-1:0], data[DATA_W-1:0].
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
- Push: on in_valid && in_ready:
  - slot[wr_ptr] gets used=1, tm=in_delay, data=in_data.
  - wr_ptr advances.
- Timers: every cycle, each slot with used=1 and tm!=0 decrements by 1. Timers stop at 0 and never wrap.
- out_valid = slot[rd_ptr].used && slot[rd_ptr].tm==0.
- out_data = slot[rd_ptr].data, driven directly from registers. There is no combinational path from any input.
- Pop: on out_valid && out_ready:
  - slot[rd_ptr].used clears.
  - rd_ptr advances.
- Order: release is strictly FIFO. An expired slot behind an unexpired head waits (head-of-line), and its timer stays at 0.
- in_ready = (count != DEPTH). It does not depend on a same-cycle pop, so when full, a push and a pop never occur in the same cycle.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- in_data contents, including the embedded valid bit, are opaque to the block.

## Timing
- Reset (rst=1 at an edge), effective from the next cycle:
  - All used=0, all tm=0.
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, out_data is don't-care (slot 0 contents).
  - in_ready=0 while rst is high, 1 in the first cycle after.
  - Reset mid-operation discards all held headers. No partial output is produced.
- Latency: a header accepted at edge t with in_delay=d, at the head and unblocked, gives out_valid=1 in the cycle after edge t+d.
  - d=0: out_valid the cycle after acceptance.
  - Maximum d is 2^TM_W-1.
- Stalled output (out_ready=0): out_valid and out_data hold stable until the transfer.
- Push into an empty ring with d=0 while the old head pops in the same cycle: both operations apply and count is unchanged.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap and no lost slot.
- Full: count=DEPTH, in_ready=0. One cycle after the pop edge, in_ready returns to 1.

## Configuration
- PKT_RING_FLUSH_EN defined:
  - Adds the flush port.
  - flush=1 at an edge sets tm=0 in every used slot. A push in the same edge also loads tm=0.
  - Headers then drain in order at one per cycle under out_ready.
  - rst has priority over flush.
- Not defined: the flush port is absent and timers are controlled only by in_delay.

## Test plan
- Reset, then push one header with in_delay=0 and out_ready=1 -> out_valid=1 with the pushed data in the cycle after acceptance; count goes 1 then 0.
- Push A (delay 5) then B (delay 0) on consecutive cycles -> B held behind A; A emitted 6 cycles after its acceptance, B on the following cycle, in order A then B.
- DEPTH=16, push 16 headers with out_ready=0 -> count=16, in_ready=0. Pop one -> in_ready=1 next cycle. Push 20 more through the ring -> pointers wrap, and the output order matches the input order with no loss.
- Hold out_ready=0 while the head is expired for 10 cycles -> out_valid stays 1 and out_data is unchanged. Release -> exactly one transfer.
- Assert rst with 7 headers held -> next cycle count=0 and out_valid=0; the following push of delay 0 is emitted alone.
- With PKT_RING_FLUSH_EN: hold 4 headers with delay 60, pulse flush -> out_valid=1 next cycle, and all 4 drain on 4 consecutive cycles in order.
